ng_exec_sequencer: RTL and testbench

- Fetch/execute sequencer for the nandgame core.
- Owns the architectural A, D and PC registers and fetches instructions from instruction memory.
- Reads `*A` from data memory when the instruction needs it, then presents instruction and operands to the combinational ALU/jump handler.
- Consumes the handler's result, jump and destination outputs to write back A, D and `*A` and to update PC.

---
 rtl/ng_exec_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ng_exec_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ng_exec_sequencer.sv
// Fetch/execute sequencer for the nandgame core: owns A, D, PC and IR,
// fetches from instruction memory, reads/writes *A through data memory and
// applies the results of the external combinational ALU/jump handler.
module ng_exec_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] instr_o,
  output logic [15:0] a_reg_o,
  output logic [15:0] d_reg_o,
  output logic [15:0] a_mem_o,
  input  logic [15:0] alu_out,
  input  logic        jmp,
  input  logic [2:0]  dst,
  output logic [15:0] pc_o,
  output logic        retire
);

  localparam int unsigned W = 16;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMWR  = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   pc, pc_nx;
  logic [W-1:0]   a, a_nx;
  logic [W-1:0]   d, d_nx;
  logic [W-1:0]   ir, ir_nx;
  logic [W-1:0]   amem, amem_nx;
  logic [W-1:0]   waddr, waddr_nx;
  logic [W-1:0]   wdata, wdata_nx;
  // Keeps a fetch request alive until acked even if run drops meanwhile.
  logic           fetch_busy, fetch_busy_nx;

  logic           imem_req_c, dmem_req_c, dmem_we_c, retire_c;
  logic [W-1:0]   dmem_addr_c;

  // State and architectural register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      a          <= '0;
      d          <= '0;
      ir         <= '0;
      amem       <= '0;
      waddr      <= '0;
      wdata      <= '0;
      fetch_busy <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      a          <= a_nx;
      d          <= d_nx;
      ir         <= ir_nx;
      amem       <= amem_nx;
      waddr      <= waddr_nx;
      wdata      <= wdata_nx;
      fetch_busy <= fetch_busy_nx;
    end
  end

  // Next-state, register next values and handshake outputs.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    a_nx          = a;
    d_nx          = d;
    ir_nx         = ir;
    amem_nx       = amem;
    waddr_nx      = waddr;
    wdata_nx      = wdata;
    fetch_busy_nx = fetch_busy;
    imem_req_c    = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    dmem_addr_c   = a;
    retire_c      = 1'b0;

    case (state)
      S_FETCH: begin
        if (run || fetch_busy) begin
          imem_req_c = 1'b1;
          if (imem_ack) begin
            ir_nx         = imem_rdata;
            fetch_busy_nx = 1'b0;
            state_nx      = S_DECODE;
          end else begin
            fetch_busy_nx = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (!ir[15]) begin
          a_nx     = ir;
          pc_nx    = pc + W'(1);
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end else if (ir[12]) begin
          state_nx = S_MEMRD;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_MEMRD: begin
        dmem_req_c  = 1'b1;
        dmem_addr_c = a;
        if (dmem_ack) begin
          amem_nx  = dmem_rdata;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        // Jump target and store address both use A as it was before write-back.
        if (dst[1]) d_nx = alu_out;
        if (dst[2]) a_nx = alu_out;
        pc_nx = jmp ? a : pc + W'(1);
        if (dst[0]) begin
          wdata_nx = alu_out;
          waddr_nx = a;
          state_nx = S_MEMWR;
        end else begin
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_MEMWR: begin
        dmem_req_c  = 1'b1;
        dmem_we_c   = 1'b1;
        dmem_addr_c = waddr;
        if (dmem_ack) begin
          retire_c = 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Requests are masked by reset so an in-flight access is dropped at once.
  assign imem_req   = imem_req_c & ~rst;
  assign dmem_req   = dmem_req_c & ~rst;
  assign dmem_we    = dmem_we_c & ~rst;
  assign retire     = retire_c & ~rst;
  assign imem_addr  = pc;
  assign dmem_addr  = dmem_addr_c;
  assign dmem_wdata = wdata;
  assign instr_o    = ir;
  assign a_reg_o    = a;
  assign d_reg_o    = d;
  assign a_mem_o    = amem;
  assign pc_o       = pc;

endmodule

// File: tb/tb_ng_exec_sequencer.sv
// Directed bench for ng_exec_sequencer: a table of one-instruction vectors
// with hand-computed results, plus hand-written run-stall and reset sequences.
module tb_ng_exec_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] instr_o;
  logic [15:0] a_reg_o;
  logic [15:0] d_reg_o;
  logic [15:0] a_mem_o;
  logic [15:0] alu_out;
  logic        jmp;
  logic [2:0]  dst;
  logic [15:0] pc_o;
  logic        retire;

  // Memory responder controls
  logic [15:0] cur_instr;
  logic [15:0] cur_drd;
  int          dlat;
  int          dcnt;
  logic        hold_ack;
  logic        force_ack;

  int n_cmp;
  int n_bad;

  ng_exec_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .instr_o(instr_o), .a_reg_o(a_reg_o), .d_reg_o(d_reg_o), .a_mem_o(a_mem_o),
    .alu_out(alu_out), .jmp(jmp), .dst(dst), .pc_o(pc_o), .retire(retire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-wait instruction memory; data memory acks after dlat wait cycles.
  assign imem_ack   = imem_req;
  assign imem_rdata = cur_instr;
  assign dmem_rdata = cur_drd;
  assign dmem_ack   = (dmem_req && (dcnt == dlat) && !hold_ack) || force_ack;

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] alu;
    logic        jmp;
    logic [2:0]  dst;
    logic [15:0] drd;
    int          dlat;
    logic [15:0] fetch;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] pc;
    logic [15:0] amem;
    int          cyc;
    logic        rd;
    logic [15:0] rd_addr;
    logic        wr;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] alu,
                              input logic j, input logic [2:0] ds,
                              input logic [15:0] drd, input int lat,
                              input logic [15:0] fetch, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] pc,
                              input logic [15:0] amem, input int cyc,
                              input logic rd, input logic [15:0] rd_addr,
                              input logic wr, input logic [15:0] wr_addr,
                              input logic [15:0] wr_data);
    vec_t v;
    v.instr = instr; v.alu = alu; v.jmp = j; v.dst = ds; v.drd = drd; v.dlat = lat;
    v.fetch = fetch; v.a = a; v.d = d; v.pc = pc; v.amem = amem; v.cyc = cyc;
    v.rd = rd; v.rd_addr = rd_addr; v.wr = wr; v.wr_addr = wr_addr; v.wr_data = wr_data;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one instruction from a FETCH cycle to retire and checks its effects.
  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    bit          done;
    bit          got_fetch;
    logic [15:0] fa;
    int          rd_n;
    int          wr_n;
    bit          rd_bad;
    bit          wr_bad;
    cur_instr = v.instr; alu_out = v.alu; jmp = v.jmp; dst = v.dst;
    cur_drd = v.drd; dlat = v.dlat;
    cyc = 0; done = 0; got_fetch = 0; fa = 16'h0000;
    rd_n = 0; wr_n = 0; rd_bad = 0; wr_bad = 0;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (imem_req && !got_fetch) begin
        fa = imem_addr;
        got_fetch = 1;
      end
      if (dmem_req && !dmem_we) begin
        rd_n++;
        if (dmem_addr !== v.rd_addr) rd_bad = 1;
      end
      if (dmem_req && dmem_we) begin
        wr_n++;
        if (dmem_addr !== v.wr_addr || dmem_wdata !== v.wr_data) wr_bad = 1;
      end
      if (retire) done = 1;
    end
    check($sformatf("v%0d_cycles", idx), 16'(cyc), 16'(v.cyc));
    check($sformatf("v%0d_fetch_addr", idx), fa, v.fetch);
    check($sformatf("v%0d_rd_cycles", idx), 16'(rd_n), v.rd ? 16'(v.dlat + 1) : 16'h0000);
    check($sformatf("v%0d_wr_cycles", idx), 16'(wr_n), v.wr ? 16'(v.dlat + 1) : 16'h0000);
    check($sformatf("v%0d_rd_addr_stable", idx), {15'h0, rd_bad}, 16'h0000);
    check($sformatf("v%0d_wr_addr_data_stable", idx), {15'h0, wr_bad}, 16'h0000);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_a", idx), a_reg_o, v.a);
    check($sformatf("v%0d_d", idx), d_reg_o, v.d);
    check($sformatf("v%0d_pc", idx), pc_o, v.pc);
    check($sformatf("v%0d_amem", idx), a_mem_o, v.amem);
    check($sformatf("v%0d_ir", idx), instr_o, v.instr);
  endtask

  vec_t tbl[16];

  initial begin
    bit seen;
    bit bad;
    int k;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; run = 1'b1;
    cur_instr = 16'h0000; cur_drd = 16'h0000; dlat = 0;
    hold_ack = 1'b0; force_ack = 1'b0;
    alu_out = 16'h0000; jmp = 1'b0; dst = 3'b000;

    //          instr     alu       j  dst     drd      lat fetch     a         d         pc        amem     cyc rd addr        wr addr      data
    tbl[0]  = mk(16'h0005, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0001, 16'h0000, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[1]  = mk(16'h0003, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0001, 16'h0003, 16'h0000, 16'h0002, 16'h0000, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[2]  = mk(16'h8010, 16'h0003, 0, 3'b010, 16'h0, 0, 16'h0002, 16'h0003, 16'h0003, 16'h0003, 16'h0000, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[3]  = mk(16'h0005, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0003, 16'h0005, 16'h0003, 16'h0004, 16'h0000, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[4]  = mk(16'h8010, 16'h0008, 0, 3'b010, 16'h0, 0, 16'h0004, 16'h0005, 16'h0008, 16'h0005, 16'h0000, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[5]  = mk(16'h0010, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0005, 16'h0010, 16'h0008, 16'h0006, 16'h0000, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[6]  = mk(16'h9000, 16'h0000, 0, 3'b000, 16'h1234, 3, 16'h0006, 16'h0010, 16'h0008, 16'h0007, 16'h1234, 7, 1, 16'h0010, 0, 16'h0,  16'h0);
    tbl[7]  = mk(16'h0020, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0007, 16'h0020, 16'h0008, 16'h0008, 16'h1234, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[8]  = mk(16'h8000, 16'h00FF, 0, 3'b101, 16'h0, 2, 16'h0008, 16'h00FF, 16'h0008, 16'h0009, 16'h1234, 6, 0, 16'h0,    1, 16'h0020, 16'h00FF);
    tbl[9]  = mk(16'h0040, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0009, 16'h0040, 16'h0008, 16'h000A, 16'h1234, 2, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[10] = mk(16'h8000, 16'h0007, 1, 3'b100, 16'h0, 0, 16'h000A, 16'h0007, 16'h0008, 16'h0040, 16'h1234, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[11] = mk(16'h9000, 16'h00AA, 0, 3'b001, 16'h5555, 0, 16'h0040, 16'h0007, 16'h0008, 16'h0041, 16'h5555, 5, 1, 16'h0007, 1, 16'h0007, 16'h00AA);
    tbl[12] = mk(16'h8000, 16'h1234, 0, 3'b000, 16'h0, 0, 16'h0041, 16'h0007, 16'h0008, 16'h0042, 16'h5555, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[13] = mk(16'h8000, 16'hFFFF, 0, 3'b100, 16'h0, 0, 16'h0042, 16'hFFFF, 16'h0008, 16'h0043, 16'h5555, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[14] = mk(16'h8000, 16'h0000, 1, 3'b000, 16'h0, 0, 16'h0043, 16'hFFFF, 16'h0008, 16'hFFFF, 16'h5555, 3, 0, 16'h0,    0, 16'h0,    16'h0);
    tbl[15] = mk(16'h0001, 16'h0000, 0, 3'b000, 16'h0, 0, 16'hFFFF, 16'h0001, 16'h0008, 16'h0000, 16'h5555, 2, 0, 16'h0,    0, 16'h0,    16'h0);

    // Reset state while run is already high
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", {15'h0, imem_req}, 16'h0000);
    check("rst_dmem_req", {15'h0, dmem_req}, 16'h0000);
    check("rst_retire", {15'h0, retire}, 16'h0000);
    check("rst_pc", pc_o, 16'h0000);
    check("rst_a", a_reg_o, 16'h0000);
    check("rst_d", d_reg_o, 16'h0000);
    check("rst_ir", instr_o, 16'h0000);
    check("rst_amem", a_mem_o, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);

    // run=0 stalls in FETCH with no request
    run = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire) bad = 1;
    end
    check("stall_no_req", {15'h0, bad}, 16'h0000);
    check("stall_pc", pc_o, 16'h0000);
    @(posedge clk);
    #1;
    run = 1'b1;

    // Reset while a write waits for its ack
    run_vec(16, mk(16'h0030, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0000, 16'h0030, 16'h0008, 16'h0001, 16'h5555, 2, 0, 16'h0, 0, 16'h0, 16'h0));
    cur_instr = 16'h8000; alu_out = 16'h0BAD; jmp = 1'b0; dst = 3'b001;
    hold_ack = 1'b1;
    seen = 0;
    k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (dmem_req && dmem_we) seen = 1;
    end
    check("wr_pending_seen", {15'h0, seen}, 16'h0001);
    check("wr_pending_addr", dmem_addr, 16'h0030);
    @(negedge clk);
    check("wr_still_waiting", {15'h0, dmem_req}, 16'h0001);
    rst = 1'b1;
    #1;
    check("midrst_dmem_req", {15'h0, dmem_req}, 16'h0000);
    check("midrst_dmem_we", {15'h0, dmem_we}, 16'h0000);
    check("midrst_pc", pc_o, 16'h0000);
    check("midrst_a", a_reg_o, 16'h0000);
    check("midrst_d", d_reg_o, 16'h0000);
    run = 1'b0;
    hold_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b1;
    #1;
    check("late_ack_retire", {15'h0, retire}, 16'h0000);
    check("late_ack_dmem_req", {15'h0, dmem_req}, 16'h0000);
    @(negedge clk);
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    check("late_ack_pc", pc_o, 16'h0000);
    check("late_ack_a", a_reg_o, 16'h0000);
    check("late_ack_amem", a_mem_o, 16'h0000);
    run = 1'b1;
    run_vec(17, mk(16'h0077, 16'h0000, 0, 3'b000, 16'h0, 0, 16'h0000, 16'h0077, 16'h0000, 16'h0001, 16'h0000, 2, 0, 16'h0, 0, 16'h0, 16'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
